tmds_encoder_multi: RTL
=======================

// Module: tmds_encoder_multi
// PURPOSE
//  Parametrised DVI/TMDS 8b/10b encoder for N colour channels at reduced input depth.
//  Sits between the video timing/framebuffer output (clk_pixel domain) and the shift-clock serialiser.
//  Generalises the fixed 3-lane 2-bit video-to-DVI path:
//   - channel count and input depth are parameters
//   - running-disparity DC balance per channel
//   - per-channel control bits
//   - fixed pipeline latency.
// PARAMETERS
//  C_channels  3  number of TMDS data lanes (1..4); lane 0 = blue, 1 = green, 2 = red
//  C_depth     2  input bits per channel (1..8), expanded to 8 bits by MSB replication
// PORTS
//  clk_pixel  in   1             pixel clock; all logic on rising edge
//  rst_n      in   1             synchronous reset, active low
//  in_data    in   C_channels*C_depth  pixel data, lane k at [k*C_depth +: C_depth]
//  in_ctl     in   2*C_channels  control pairs {c1,c0} per lane at [2k +: 2]; lane 0 = {vsync,hsync}
//  in_blank   in   1             1 = blanking (control symbols), 0 = active video
//  out_tmds   out  10*C_channels  encoded symbols, lane k at [10k +: 10], bit 0 transmitted first
//  out_blank  out  1             in_blank delayed to align with out_tmds
// BEHAVIOUR
//  - Reset (rst_n=0 at clk edge): every lane out_tmds=10'h354 (ctl 00); out_blank=1; disparity counters=0; pipeline regs cleared to blank/ctl 00.
//  - Latency: 2 clk_pixel cycles, in_* to out_tmds/out_blank; one symbol per cycle, no stalls.
//  - Expansion: d8 = top 8 bits of {in,in,...} replicated (depth 2: 2'b10 -> 8'hAA; depth 1: 1 -> 8'hFF); depth 8 = pass-through.
//  - Stage 1 (registered): n1=popcount(d8).
//     - XNOR mode if n1>4 or (n1==4 and d8[0]==0), else XOR.
//     - q_m[0]=d8[0]; q_m[i]=q_m[i-1] xor/xnor d8[i]; q_m[8]=1 for XOR, 0 for XNOR.
//     - Also register blank and ctl.
//  - Stage 2 (registered), per lane, signed 5-bit cnt; N1/N0 = ones/zeros of q_m[7:0]:
//     - cnt==0 or N1==N0: out={~q_m8,q_m8, q_m8?q_m[7:0]:~q_m[7:0]}; cnt += q_m8?(N1-N0):(N0-N1)
//     - (cnt>0&&N1>N0)||(cnt<0&&N0>N1): out={1,q_m8,~q_m[7:0]}; cnt += 2*q_m8 + (N0-N1)
//     - else: out={0,q_m8,q_m[7:0]}; cnt += -2*(~q_m8) + (N1-N0)
//  - Blank cycle: out = ctl code (00->354, 01->0AB, 10->154, 11->2AB hex); cnt forced to 0.
//  - cnt arithmetic in 5-bit two's complement; |cnt| never exceeds 10, no wrap.
//  - Blank<->active edges take effect on the exact aligned symbol; no gap or duplicate symbols.
//  - Reset mid-frame: pipeline contents discarded; first post-reset symbols are control 354 until valid data propagates.
// CONFIGURATION
//  TMDS_GUARD_BAND_EN defined:
//   - data path gets 2 extra delay stages; latency becomes 4 cycles.
//   - The 2 blank symbols immediately preceding each active period are replaced by HDMI video guard band:
//      - lanes 0 and 2: 10'h2CC; lane 1: 10'h133; lanes >=3: 10'h2CC.
//   - cnt is still 0 at first active pixel.
//   - Blank periods shorter than 2 cycles: guard bytes cover the whole blank period (no control symbol emitted).
//  Undefined: latency 2, no guard band, plain DVI.
// TESTING
//  1 Reset: hold rst_n=0 3 cycles -> every lane out_tmds=10'h354, out_blank=1.
//  2 Blank, in_ctl lane0=2'b01 (hsync) -> lane0 out 10'h0AB, lanes1-2 out 10'h354 exactly 2 cycles later.
//  3 C_depth=8, active, lane0 data 8'h00 for 2 pixels -> 10'h100 then 10'h3FF; cnt -8 then +2.
//  4 C_depth=2, active, data 2'b11 after blank -> 10'h200 (XNOR path, inverted); C_depth=2 data 2'b10 -> d8=8'hAA symbol matches reference model.
//  5 Random 10k active pixels, blanks every 1344 cycles -> out matches golden model; decoded disparity |cnt|<=10.
//  6 TMDS_GUARD_BAND_EN: blank 10 cycles then active -> symbols 8,9 of blank are 2CC/133/2CC, first data symbol at latency 4.

Source files
------------

// File: rtl/tmds_encoder_multi.sv
// tmds_encoder_multi
//   DVI/TMDS 8b/10b encoder for C_channels lanes fed with C_depth-bit colour
//   samples. Each sample is widened to 8 bits by repeating its bit pattern from
//   the MSB down. Stage 1 minimises transitions (q_m). Stage 2 balances running
//   disparity per lane, or emits a control symbol during blanking.
//
//   Optional build macro TMDS_GUARD_BAND_EN:
//     - adds two output delay stages, so latency grows from 2 to 4 cycles;
//     - replaces the two blank symbols just before each active period with the
//       HDMI video guard band (lane 1: 10'h133, every other lane: 10'h2CC).
//
// Ports
//   clk_pixel  pixel clock; all logic runs on the rising edge
//   rst_n      synchronous reset, active low
//   in_data    pixel data; lane k is at [k*C_depth +: C_depth]
//   in_ctl     control pair {c1,c0} per lane at [2k +: 2]; lane 0 = {vsync,hsync}
//   in_blank   1 = blanking (control symbols), 0 = active video
//   out_tmds   10-bit symbol per lane at [10k +: 10]; bit 0 is sent first
//   out_blank  in_blank delayed to line up with out_tmds
module tmds_encoder_multi #(
  parameter int C_channels = 3,
  parameter int C_depth    = 2
) (
  input  logic                            clk_pixel,
  input  logic                            rst_n,
  input  logic [C_channels*C_depth-1:0]   in_data,
  input  logic [2*C_channels-1:0]         in_ctl,
  input  logic                            in_blank,
  output logic [10*C_channels-1:0]        out_tmds,
  output logic                            out_blank
);

  localparam logic [9:0] CTL_00 = 10'h354;

  function automatic logic [7:0] expand(input logic [C_depth-1:0] v);
    logic [8*C_depth-1:0] rep;
    rep = {8{v}};
    return rep[8*C_depth-1 -: 8];
  endfunction

  function automatic logic [3:0] ones8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

  function automatic logic [8:0] qm_of(input logic [7:0] d);
    logic [3:0] n1;
    logic       use_xnor;
    logic [8:0] q;
    n1       = ones8(d);
    use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
    q[0]     = d[0];
    for (int i = 1; i < 8; i++) q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    q[8]     = ~use_xnor;
    return q;
  endfunction

  function automatic logic [9:0] ctl_code(input logic [1:0] c);
    logic [9:0] s;
    case (c)
      2'b00:   s = 10'h354;
      2'b01:   s = 10'h0AB;
      2'b10:   s = 10'h154;
      default: s = 10'h2AB;
    endcase
    return s;
  endfunction

  // Returns {next_cnt[4:0], symbol[9:0]}. The disparity math runs at 6 bits,
  // so 2*N1 (up to 16) cannot overflow. |cnt| stays within 10, so the stored
  // 5-bit value never wraps.
  function automatic logic [14:0] encode(input logic       blank,
                                         input logic [1:0] ctl,
                                         input logic [8:0] qm,
                                         input logic [4:0] cnt);
    logic [3:0]        n1;
    logic signed [5:0] bal;
    logic signed [5:0] cur;
    logic signed [5:0] nxt;
    logic [9:0]        sym;
    n1  = ones8(qm[7:0]);
    bal = $signed({1'b0, n1, 1'b0}) - 6'sd8;
    cur = $signed({cnt[4], cnt});
    if (blank) begin
      sym = ctl_code(ctl);
      nxt = 6'sd0;
    end else if ((cur == 6'sd0) || (bal == 6'sd0)) begin
      sym = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      nxt = qm[8] ? (cur + bal) : (cur - bal);
    end else if (((cur > 6'sd0) && (bal > 6'sd0)) || ((cur < 6'sd0) && (bal < 6'sd0))) begin
      sym = {1'b1, qm[8], ~qm[7:0]};
      nxt = cur + (qm[8] ? 6'sd2 : 6'sd0) - bal;
    end else begin
      sym = {1'b0, qm[8], qm[7:0]};
      nxt = cur - (qm[8] ? 6'sd0 : 6'sd2) + bal;
    end
    return {nxt[4:0], sym};
  endfunction

  logic s1_blank;
  logic s2_blank;

`ifdef TMDS_GUARD_BAND_EN
  logic s3_blank;
  logic s4_blank;
  // The symbol moving into the last stage is a guard symbol when it is blank
  // and either of the next two symbols (now in s2/s1) is active video.
  logic guard_load;
  assign guard_load = s3_blank && (!s2_blank || !s1_blank);
  assign out_blank  = s4_blank;
`else
  assign out_blank  = s2_blank;
`endif

  always_ff @(posedge clk_pixel) begin
    if (!rst_n) begin
      s1_blank <= 1'b1;
      s2_blank <= 1'b1;
`ifdef TMDS_GUARD_BAND_EN
      s3_blank <= 1'b1;
      s4_blank <= 1'b1;
`endif
    end else begin
      s1_blank <= in_blank;
      s2_blank <= s1_blank;
`ifdef TMDS_GUARD_BAND_EN
      s3_blank <= s2_blank;
      s4_blank <= s3_blank;
`endif
    end
  end

  genvar k;
  generate
    for (k = 0; k < C_channels; k++) begin : g_lane
      logic [8:0]  s1_qm;
      logic [1:0]  s1_ctl;
      logic [9:0]  s2_sym;
      logic [4:0]  cnt;
      logic [14:0] enc;

      assign enc = encode(s1_blank, s1_ctl, s1_qm, cnt);

      always_ff @(posedge clk_pixel) begin
        if (!rst_n) begin
          s1_qm  <= '0;
          s1_ctl <= 2'b00;
          s2_sym <= CTL_00;
          cnt    <= '0;
        end else begin
          s1_qm  <= qm_of(expand(in_data[k*C_depth +: C_depth]));
          s1_ctl <= in_ctl[2*k +: 2];
          s2_sym <= enc[9:0];
          cnt    <= enc[14:10];
        end
      end

`ifdef TMDS_GUARD_BAND_EN
      localparam logic [9:0] GUARD_SYM = (k == 1) ? 10'h133 : 10'h2CC;
      logic [9:0] s3_sym;
      logic [9:0] s4_sym;
      always_ff @(posedge clk_pixel) begin
        if (!rst_n) begin
          s3_sym <= CTL_00;
          s4_sym <= CTL_00;
        end else begin
          s3_sym <= s2_sym;
          s4_sym <= guard_load ? GUARD_SYM : s3_sym;
        end
      end
      assign out_tmds[10*k +: 10] = s4_sym;
`else
      assign out_tmds[10*k +: 10] = s2_sym;
`endif
    end
  endgenerate

endmodule
